// File: rtl/crc_serial_checker_pkg.sv
// ============================================================================
// Module  : crc_serial_checker_pkg
// Brief   : Shared types, default constants and the serial CRC step function.
// Revision: 1.0
// ============================================================================
`default_nettype none

package crc_serial_checker_pkg;

    localparam int          C_MAX_WIDTH    = 16;
    localparam int          C_CNT_W        = 16;
    localparam logic [15:0] C_DEFAULT_POLY = 16'h0007;
    localparam logic [15:0] C_DEFAULT_INIT = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One MSB-first shift of the CRC register; msb selects the active top bit
    // so narrower registers can share the 16-bit datapath and truncate.
    function automatic logic [15:0] crc_step(input logic [15:0] q,
                                             input logic        d,
                                             input logic [15:0] poly,
                                             input logic [3:0]  msb);
        logic w_fb;
        w_fb = q[msb] ^ d;
        return {q[14:0], 1'b0} ^ (w_fb ? poly : 16'h0000);
    endfunction

endpackage

`default_nettype wire

// File: rtl/crc_serial_lfsr.sv
// ============================================================================
// Module  : crc_serial_lfsr
// Brief   : CRC register with load-from-INIT and shift-enable controls.
// Revision: 1.0
// ============================================================================
`default_nettype none

module crc_serial_lfsr
    import crc_serial_checker_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = C_DEFAULT_POLY[WIDTH-1:0],
    parameter logic [WIDTH-1:0] INIT  = C_DEFAULT_INIT[WIDTH-1:0]
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_en,
    input  logic             i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_next;

    // A load restarts the frame: the first bit is folded into INIT directly.
    assign w_base = i_load ? INIT : r_q;
    assign w_next = WIDTH'(crc_step(16'(w_base), i_d, 16'(POLY), 4'(WIDTH - 1)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= INIT;
        end else if (i_load || i_en) begin
            r_q <= w_next;
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/crc_serial_checker.sv
// ============================================================================
// Module  : crc_serial_checker
// Brief   : Serial CRC residue checker with frame FSM and pass/fail strobe.
// Revision: 1.0
// ============================================================================
`default_nettype none

module crc_serial_checker
    import crc_serial_checker_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] POLY     = C_DEFAULT_POLY[WIDTH-1:0],
    parameter logic [WIDTH-1:0] INIT     = C_DEFAULT_INIT[WIDTH-1:0],
    parameter int               MIN_BITS = 9
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             D,
    input  logic             DV,
    input  logic             SOF,
    input  logic             EOF,
    output logic [WIDTH-1:0] Q,
    output logic             Z,
    output logic             ZV,
    output logic             BUSY,
    output logic             ABORT,
    inout  wire              VDD,
    inout  wire              VSS
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [C_CNT_W-1:0] r_cnt;
    logic [C_CNT_W-1:0] w_cnt_nxt;
    logic               r_abort;
    logic               w_abort_nxt;
    logic               w_load;
    logic               w_en;

    wire w_unused_supply = VDD ^ VSS;

    crc_serial_lfsr #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .INIT  (INIT)
    ) u_lfsr (
        .i_clk   (CLK),
        .i_rst_n (RN),
        .i_load  (w_load),
        .i_en    (w_en),
        .i_d     (D),
        .o_q     (Q)
    );

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_abort <= w_abort_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_abort_nxt = 1'b0;
        w_load      = 1'b0;
        w_en        = 1'b0;
        case (r_state)
            // DONE accepts a new SOF exactly like IDLE so frames can abut.
            ST_IDLE, ST_DONE: begin
                w_state_nxt = ST_IDLE;
                if (DV && SOF) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = C_CNT_W'(1);
                    w_state_nxt = EOF ? ST_DONE : ST_ACC;
                end
            end
            ST_ACC: begin
                if (DV) begin
                    if (SOF) begin
                        w_load      = 1'b1;
                        w_cnt_nxt   = C_CNT_W'(1);
                        w_abort_nxt = 1'b1;
                    end else begin
                        w_en = 1'b1;
                        if (r_cnt != '1) begin
                            w_cnt_nxt = r_cnt + C_CNT_W'(1);
                        end
                    end
                    w_state_nxt = EOF ? ST_DONE : ST_ACC;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign ZV    = (r_state == ST_DONE);
    assign Z     = ZV && (Q == '0) && (r_cnt >= C_CNT_W'(MIN_BITS));
    assign BUSY  = (r_state == ST_ACC);
    assign ABORT = r_abort;

endmodule

`default_nettype wire

// File: tb/tb_crc_serial_checker.sv
// ============================================================================
// Module  : tb_crc_serial_checker
// Brief   : Scoreboard bench for crc_serial_checker (CRC-8, poly 0x07).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_crc_serial_checker;

    localparam logic [7:0] C_POLY = 8'h07;
    localparam int         C_MIN  = 9;

    logic       CLK = 1'b0;
    logic       RN  = 1'b0;
    logic       D   = 1'b0;
    logic       DV  = 1'b0;
    logic       SOF = 1'b0;
    logic       EOF = 1'b0;
    logic [7:0] Q;
    logic       Z;
    logic       ZV;
    logic       BUSY;
    logic       ABORT;
    wire        vdd = 1'b1;
    wire        vss = 1'b0;

    crc_serial_checker dut (
        .CLK   (CLK),
        .RN    (RN),
        .D     (D),
        .DV    (DV),
        .SOF   (SOF),
        .EOF   (EOF),
        .Q     (Q),
        .Z     (Z),
        .ZV    (ZV),
        .BUSY  (BUSY),
        .ABORT (ABORT),
        .VDD   (vdd),
        .VSS   (vss)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       z;
        logic [7:0] q;
    } res_t;

    res_t       exp_q[$];
    res_t       mon_e;
    int         n_checks  = 0;
    int         n_fail    = 0;
    int         n_push    = 0;
    int         n_zv      = 0;
    int         exp_abort = 0;
    int         got_abort = 0;
    logic [7:0] m_q       = 8'h00;
    int         m_cnt     = 0;
    bit         m_open    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] ref_step(input logic [7:0] q, input logic d);
        return (q << 1) ^ ((q[7] ^ d) ? C_POLY : 8'h00);
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            DV  = 1'b0;
            D   = 1'($urandom);
            SOF = 1'($urandom);
            EOF = 1'($urandom);
        end
    endtask

    task automatic send_bit(input logic d, input logic sof, input logic eof, input int gap_max);
        if (!sof) idle(int'($urandom_range(gap_max, 0)));
        @(negedge CLK);
        D   = d;
        DV  = 1'b1;
        SOF = sof;
        EOF = eof;
        if (sof) begin
            if (m_open) exp_abort++;
            m_q    = ref_step(8'h00, d);
            m_cnt  = 1;
            m_open = 1'b1;
        end else begin
            m_q = ref_step(m_q, d);
            m_cnt++;
        end
        if (eof) begin
            exp_q.push_back({(m_q == 8'h00) && (m_cnt >= C_MIN), m_q});
            n_push++;
            m_open = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic sof, input logic eof, input int gap);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i], sof && (i == 7), eof && (i == 0), gap);
        end
    endtask

    always @(posedge CLK) begin
        #1;
        if (ABORT) begin
            got_abort++;
            chk("abort_busy", 32'(BUSY), 32'd1);
        end
        if (ZV) begin
            n_zv++;
            if (exp_q.size() == 0) begin
                chk("zv_unexpected", n_zv, n_push);
            end else begin
                mon_e = exp_q.pop_front();
                chk("result_z", 32'(Z), 32'(mon_e.z));
                chk("result_q", 32'(Q), 32'(mon_e.q));
                chk("done_busy", 32'(BUSY), 32'd0);
            end
        end
    end

    initial begin
        logic [7:0] b;
        logic [7:0] c;

        repeat (3) @(posedge CLK);
        #1;
        chk("reset_q", 32'(Q), 32'h00);
        chk("reset_z", 32'(Z), 32'd0);
        chk("reset_zv", 32'(ZV), 32'd0);
        chk("reset_busy", 32'(BUSY), 32'd0);
        chk("reset_abort", 32'(ABORT), 32'd0);
        @(negedge CLK);
        RN = 1'b1;
        idle(2);

        // good frame, with mid-frame register check
        send_byte(8'h01, 1'b1, 1'b0, 0);
        @(posedge CLK);
        #1;
        chk("q_after_byte", 32'(Q), 32'h07);
        chk("busy_open", 32'(BUSY), 32'd1);
        send_byte(8'h07, 1'b0, 1'b1, 0);
        idle(3);

        // corrupt crc
        send_byte(8'h01, 1'b1, 1'b0, 0);
        send_byte(8'h06, 1'b0, 1'b1, 0);
        idle(3);

        // short frame and one-bit frame
        send_byte(8'h00, 1'b1, 1'b1, 0);
        idle(3);
        send_bit(1'b1, 1'b1, 1'b1, 0);
        idle(3);

        // restart after 5 bits
        for (int i = 0; i < 5; i++) send_bit(1'($urandom), i == 0, 1'b0, 0);
        send_byte(8'h00, 1'b1, 1'b0, 0);
        send_byte(8'h00, 1'b0, 1'b1, 0);
        idle(3);

        // back-to-back frames with random DV gaps
        b = 8'($urandom);
        c = 8'h00;
        for (int i = 7; i >= 0; i--) c = ref_step(c, b[i]);
        send_byte(b, 1'b1, 1'b0, 3);
        send_byte(c, 1'b0, 1'b1, 3);
        send_byte(8'h01, 1'b1, 1'b0, 3);
        send_byte(8'h07, 1'b0, 1'b1, 3);
        idle(4);

        // asynchronous reset mid-frame
        send_byte(8'hA5, 1'b1, 1'b0, 0);
        send_bit(1'b1, 1'b0, 1'b0, 0);
        @(negedge CLK);
        DV = 1'b0;
        #2;
        RN = 1'b0;
        #1;
        chk("midrst_q", 32'(Q), 32'h00);
        chk("midrst_busy", 32'(BUSY), 32'd0);
        chk("midrst_zv", 32'(ZV), 32'd0);
        m_open = 1'b0;
        repeat (2) @(negedge CLK);
        RN = 1'b1;
        idle(6);

        // recovery frame
        send_byte(8'h01, 1'b1, 1'b0, 0);
        send_byte(8'h07, 1'b0, 1'b1, 0);
        idle(3);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge CLK);
        #2;
        chk("pending_results", exp_q.size(), 32'd0);
        chk("zv_count", n_zv, n_push);
        chk("abort_count", got_abort, exp_abort);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
